seven_seg_scan_drv: RTL and testbench
=====================================

# seven_seg_scan_drv

Parametrised multiplexed seven-segment display driver for the board-level debug display shared by the N64 and GC controller designs. It scans NUM_DIGITS common-anode or common-cathode digits with a programmable per-digit period and decodes one hex nibble per digit. It adds per-digit decimal points, leading-zero blanking, PWM brightness, an enable, an anti-ghosting guard slot and a frame-done strobe. All display inputs are snapshotted once per frame, so a frame never shows a torn value.

## Interface
- NUM_DIGITS, 4: digits scanned, 1..8.
- DIGIT_PERIOD, 262144: clocks per digit slot; power of two, ≥ 2^(BRIGHT_BITS+1).
- BRIGHT_BITS, 4: brightness control width.
- DIG_ACTIVE_LOW, 1: polarity of dig enables.
- SEG_ACTIVE_LOW, 1: polarity of seg lines.

Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- enable  in  1  scan enable; 0 blanks the display.
- disp_num  in  4*NUM_DIGITS  hex value; MS nibble is digit 0, the leftmost digit.
- dp  in  NUM_DIGITS  decimal-point enables; dp[NUM_DIGITS-1] is digit 0.
- lz_blank  in  1  blank leading zero digits.
- brightness  in  BRIGHT_BITS  duty level.
- dig  out  NUM_DIGITS  digit enables; dig[NUM_DIGITS-1] is digit 0; one-hot active.
- seg  out  8  {dp,g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- FSM states:
  - IDLE: counters held at 0.
  - SCAN.
- IDLE→SCAN when enable=1. The transition loads the snapshot (disp_num, dp, lz_blank) and sets digit_idx=0, tick=0.
- SCAN→IDLE on enable=0, from any tick or digit.
- In SCAN, tick counts 0..DIGIT_PERIOD-1.
  - At DIGIT_PERIOD-1, tick wraps and digit_idx increments.
  - At digit_idx=NUM_DIGITS-1 with tick=DIGIT_PERIOD-1: digit_idx wraps to 0, a new snapshot loads, and frame_done is asserted.
- brightness is sampled live, not snapshotted.
- Decode uses the standard hex glyph table (0–9, A, b, C, d, E, F), held as active-high constants and inverted if SEG_ACTIVE_LOW.
- Leading-zero blank: digit i is blanked when lz_blank is set, nibbles 0..i are all zero, and i≠NUM_DIGITS-1. The last digit always shows. A blanked digit shows no segments a–g but still honours dp.
- Digit on-condition, all of:
  - state=SCAN;
  - tick≠0 (guard slot against ghosting);
  - slot<brightness, or brightness is all-ones (full duty). slot = tick[log2(DIGIT_PERIOD)-1 -: BRIGHT_BITS].
- brightness=0 means the digit is never lit.
- When the on-condition fails, dig and seg are both driven inactive.

## Timing
- dig, seg and frame_done are registered. Each output at cycle t+1 reflects the state/tick/digit_idx of cycle t: one-cycle latency.
- Reset values:
  - dig all inactive: all-ones if DIG_ACTIVE_LOW, else 0.
  - seg all off: 8'hFF if SEG_ACTIVE_LOW, else 0.
  - frame_done=0; state=IDLE; snapshot=0.
- With enable=1 at reset release: the first edge loads the snapshot; dig first goes active 2 cycles after entering SCAN (tick=1, plus the register stage).
- Frame length is exactly NUM_DIGITS*DIGIT_PERIOD clocks. frame_done pulses once per frame, one cycle after the last tick.
- enable dropped mid-frame: the output is blank on the next edge, no frame_done is issued, and the partial frame is discarded. Re-enable restarts at digit 0 with a fresh snapshot.
- disp_num changes mid-frame: no visible effect until the next frame boundary.
- Asynchronous reset mid-scan: outputs go inactive immediately.

## Structure
- Package seven_seg_pkg holds:
  - the 16-entry active-high glyph constant array;
  - the DP bit index constant;
  - the state enum typedef (IDLE, SCAN).
- Sub-module seg_hex_decode: combinational nibble + blank + dp → active-high 8-bit segments. Polarity is applied in the top level.
- The top level holds the FSM, counters, snapshot registers, PWM compare and output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, DIGIT_PERIOD=64, BRIGHT_BITS=4, both polarities active-low.
- Reset check: hold reset, then release with enable=0 → dig=4'hF, seg=8'hFF, frame_done=0 indefinitely.
- Basic decode: enable=1, disp_num=16'h1A3F, brightness=4'hF → per slot:
  - dig=0111, seg=F9;
  - dig=1011, seg=88;
  - dig=1101, seg=B0;
  - dig=1110, seg=8E;
  - frame_done every 256 clocks; tick=0 guard cycles are blank.
- Leading zeros: disp_num=16'h0005, lz_blank=1, dp=4'b0100 → digit0 blank (FF); digit1 seg=7F (DP only); digit2 blank; digit3 seg=92. With disp_num=16'h0000, digit3 shows C0.
- Snapshot: change disp_num from 16'h1234 to 16'h5678 during the digit-2 slot → rest of frame shows 3,4; the next frame shows 5,6,7,8.
- Brightness: brightness=4 → each digit lit for slots 0..3 minus the guard tick, i.e. 15 of 64 clocks. brightness=0 → never lit.
- Enable drop: deassert enable during digit 1 → blank on the next edge, no frame_done. Reassert → digit 0 first, frame_done after 256 more clocks.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seven_seg_pkg;

  // Segment bit position of the decimal point in {dp,g,f,e,d,c,b,a}.
  localparam int DP_BIT = 7;

  // Active-high hex glyphs {dp,g,f,e,d,c,b,a}: 0-9, A, b, C, d, E, F.
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,
    8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C,
    8'h39, 8'h5E, 8'h79, 8'h71
  };

  // Scan controller states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder producing active-high segments.
// Blanking suppresses a-g only; the decimal point is always honoured.
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg_hi
);

  // Look up the glyph, suppress it when blanked, then overlay the decimal point.
  always_comb begin
    seg_hi = 8'h00;
    if (blank) begin
      seg_hi = 8'h00;
    end else begin
      seg_hi = GLYPH_TABLE[nibble];
    end
    seg_hi[DP_BIT] = dp;
  end

endmodule

// File: rtl/seven_seg_scan_drv.sv
// Multiplexed seven-segment scan driver: per-frame snapshot of the display
// inputs, per-digit slot timing with a tick-0 anti-ghosting guard, PWM
// brightness, leading-zero blanking and a registered frame-done strobe.
module seven_seg_scan_drv
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_PERIOD   = 262144,
  parameter int BRIGHT_BITS    = 4,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] disp_num,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int TICK_W = $clog2(DIGIT_PERIOD);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0]     TICK_MAX = TICK_W'(DIGIT_PERIOD - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_OFF  =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  state_e                  state_r;
  logic [TICK_W-1:0]       tick_r;
  logic [IDX_W-1:0]        digit_idx_r;
  logic [4*NUM_DIGITS-1:0] snap_num_r;
  logic [NUM_DIGITS-1:0]   snap_dp_r;
  logic                    snap_lz_r;
  logic [NUM_DIGITS-1:0]   dig_r;
  logic [7:0]              seg_r;
  logic                    frame_done_r;

  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic [NUM_DIGITS-1:0]   dig_hi_s;
  logic [7:0]              seg_hi_s;
  logic [BRIGHT_BITS-1:0]  slot_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   dig_next_s;
  logic [7:0]              seg_next_s;

  // Select the current digit's nibble/dp, its one-hot enable, and whether it is a leading zero.
  always_comb begin
    logic zero_run_s;
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    dig_hi_s    = {NUM_DIGITS{1'b0}};
    zero_run_s  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run_s = zero_run_s & (snap_num_r[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if (IDX_W'(i) == digit_idx_r) begin
        cur_nib_s   = snap_num_r[4*(NUM_DIGITS-1-i) +: 4];
        cur_dp_s    = snap_dp_r[NUM_DIGITS-1-i];
        cur_blank_s = snap_lz_r & zero_run_s & (i != NUM_DIGITS - 1);
        dig_hi_s[NUM_DIGITS-1-i] = 1'b1;
      end else begin
        dig_hi_s[NUM_DIGITS-1-i] = 1'b0;
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble (cur_nib_s),
    .blank  (cur_blank_s),
    .dp     (cur_dp_s),
    .seg_hi (seg_hi_s)
  );

  // Digit on-condition: scanning, past the guard tick, and inside the PWM window.
  // enable is included so a dropped enable blanks on the very next edge.
  always_comb begin
    slot_s = tick_r[TICK_W-1 -: BRIGHT_BITS];
    lit_s  = 1'b0;
    if ((state_r == SCAN) && enable && (tick_r != {TICK_W{1'b0}})) begin
      lit_s = (&brightness) | (slot_s < brightness);
    end else begin
      lit_s = 1'b0;
    end
    if (lit_s) begin
      dig_next_s = (DIG_ACTIVE_LOW != 0) ? ~dig_hi_s : dig_hi_s;
      seg_next_s = (SEG_ACTIVE_LOW != 0) ? ~seg_hi_s : seg_hi_s;
    end else begin
      dig_next_s = DIG_OFF;
      seg_next_s = SEG_OFF;
    end
  end

  // Scan FSM, tick/digit counters, frame snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      tick_r       <= {TICK_W{1'b0}};
      digit_idx_r  <= {IDX_W{1'b0}};
      snap_num_r   <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_r    <= {NUM_DIGITS{1'b0}};
      snap_lz_r    <= 1'b0;
      dig_r        <= DIG_OFF;
      seg_r        <= SEG_OFF;
      frame_done_r <= 1'b0;
    end else begin
      dig_r        <= dig_next_s;
      seg_r        <= seg_next_s;
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tick_r      <= {TICK_W{1'b0}};
          digit_idx_r <= {IDX_W{1'b0}};
          if (enable) begin
            state_r    <= SCAN;
            snap_num_r <= disp_num;
            snap_dp_r  <= dp;
            snap_lz_r  <= lz_blank;
          end
        end
        SCAN: begin
          if (!enable) begin
            state_r     <= IDLE;
            tick_r      <= {TICK_W{1'b0}};
            digit_idx_r <= {IDX_W{1'b0}};
          end else if (tick_r == TICK_MAX) begin
            tick_r <= {TICK_W{1'b0}};
            if (digit_idx_r == IDX_LAST) begin
              digit_idx_r  <= {IDX_W{1'b0}};
              snap_num_r   <= disp_num;
              snap_dp_r    <= dp;
              snap_lz_r    <= lz_blank;
              frame_done_r <= 1'b1;
            end else begin
              digit_idx_r <= digit_idx_r + IDX_W'(1);
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          tick_r      <= {TICK_W{1'b0}};
          digit_idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign dig        = dig_r;
  assign seg        = seg_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_drv.sv
// Directed, table-driven bench for seven_seg_scan_drv (4 digits, 64-clock slots,
// both polarities active-low). Inputs change and outputs are sampled on negedges.
module tb_seven_seg_scan_drv;

  localparam int ND = 4;
  localparam int DP = 64;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   disp_num = 16'h0000;
  logic [3:0]    dp = 4'h0;
  logic          lz_blank = 1'b0;
  logic [3:0]    brightness = 4'h0;
  logic [3:0]    dig;
  logic [7:0]    seg;
  logic          frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  seven_seg_scan_drv #(
    .NUM_DIGITS(ND), .DIGIT_PERIOD(DP), .BRIGHT_BITS(BB),
    .DIG_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .disp_num(disp_num),
    .dp(dp), .lz_blank(lz_blank), .brightness(brightness),
    .dig(dig), .seg(seg), .frame_done(frame_done)
  );

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dpv;
    logic        lz;
    logic [3:0]  br;
    int          c;
    logic [3:0]  edig;
    logic [7:0]  eseg;
  } vec_t;

  vec_t vecs [20];

  task automatic nstep(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Return to IDLE, apply inputs, enable; cyc=0 marks the enabling negedge.
  task automatic start(input logic [15:0] n, input logic [3:0] d, input logic l, input logic [3:0] b);
    enable = 1'b0;
    nstep(3);
    disp_num = n; dp = d; lz_blank = l; brightness = b;
    enable = 1'b1;
    cyc = 0;
  endtask

  // Advance until the outputs reflect scan cycle c (tick c%64 of digit c/64).
  task automatic goto_c(input int c);
    if (c + 2 > cyc) nstep(c + 2 - cyc);
  endtask

  initial begin
    int cnt;
    logic [3:0] exp_dig;

    vecs[0]  = '{16'h1A3F, 4'h0, 1'b0, 4'hF,   1, 4'h7, 8'hF9};
    vecs[1]  = '{16'h1A3F, 4'h0, 1'b0, 4'hF,  65, 4'hB, 8'h88};
    vecs[2]  = '{16'h1A3F, 4'h0, 1'b0, 4'hF, 158, 4'hD, 8'hB0};
    vecs[3]  = '{16'h1A3F, 4'h0, 1'b0, 4'hF, 255, 4'hE, 8'h8E};
    vecs[4]  = '{16'h1A3F, 4'h0, 1'b0, 4'hF,   0, 4'hF, 8'hFF};
    vecs[5]  = '{16'h1A3F, 4'h0, 1'b0, 4'hF,  64, 4'hF, 8'hFF};
    vecs[6]  = '{16'h0005, 4'h4, 1'b1, 4'hF,  10, 4'h7, 8'hFF};
    vecs[7]  = '{16'h0005, 4'h4, 1'b1, 4'hF,  74, 4'hB, 8'h7F};
    vecs[8]  = '{16'h0005, 4'h4, 1'b1, 4'hF, 138, 4'hD, 8'hFF};
    vecs[9]  = '{16'h0005, 4'h4, 1'b1, 4'hF, 202, 4'hE, 8'h92};
    vecs[10] = '{16'h0000, 4'h0, 1'b1, 4'hF, 202, 4'hE, 8'hC0};
    vecs[11] = '{16'h0000, 4'h0, 1'b1, 4'hF,  10, 4'h7, 8'hFF};
    vecs[12] = '{16'h0005, 4'h0, 1'b0, 4'hF,  10, 4'h7, 8'hC0};
    vecs[13] = '{16'h1A3F, 4'h0, 1'b0, 4'h4,  15, 4'h7, 8'hF9};
    vecs[14] = '{16'h1A3F, 4'h0, 1'b0, 4'h4,  16, 4'hF, 8'hFF};
    vecs[15] = '{16'h1A3F, 4'h0, 1'b0, 4'h0,   1, 4'hF, 8'hFF};
    vecs[16] = '{16'h1A3F, 4'h0, 1'b0, 4'h0,   8, 4'hF, 8'hFF};
    vecs[17] = '{16'h1A3F, 4'hF, 1'b0, 4'hF, 257, 4'h7, 8'h79};
    vecs[18] = '{16'h1A3F, 4'h0, 1'b0, 4'h7,  27, 4'h7, 8'hF9};
    vecs[19] = '{16'h1A3F, 4'h0, 1'b0, 4'h7,  28, 4'hF, 8'hFF};

    // Reset: inactive during reset and indefinitely after release with enable=0.
    nstep(3);
    check("rst_hold", {frame_done, dig, seg}, {1'b0, 4'hF, 8'hFF});
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      nstep(1);
      check("rst_idle", {frame_done, dig, seg}, {1'b0, 4'hF, 8'hFF});
    end

    // Table-driven decode / blanking / brightness vectors.
    for (int i = 0; i < 20; i++) begin
      start(vecs[i].num, vecs[i].dpv, vecs[i].lz, vecs[i].br);
      goto_c(vecs[i].c);
      check($sformatf("vec%0d", i), {dig, seg}, {vecs[i].edig, vecs[i].eseg});
    end

    // Frame timing: frame_done at 256-clock spacing, guard ticks blank, digit order.
    start(16'h1A3F, 4'h0, 1'b0, 4'hF);
    for (int k = 1; k <= 600; k++) begin
      nstep(1);
      check("frame_done", {31'd0, frame_done}, {31'd0, (cyc == 257 || cyc == 513)});
      if (cyc >= 2 && (cyc - 2) % DP == 0) check("guard", {28'd0, dig}, 32'h0000000F);
      if (cyc >= 2 && (cyc - 2) % DP == 5) begin
        exp_dig = ~(4'b1000 >> (((cyc - 2) / DP) % ND));
        check("digit_order", {28'd0, dig}, {28'd0, exp_dig});
      end
    end

    // Brightness duty: lit clocks within digit 0's slot.
    start(16'h1A3F, 4'h0, 1'b0, 4'h4);
    cnt = 0;
    for (int c = 0; c < DP; c++) begin
      goto_c(c);
      if (dig != 4'hF) cnt++;
    end
    check("bright4_count", cnt, 15);
    start(16'h1A3F, 4'h0, 1'b0, 4'h0);
    cnt = 0;
    for (int c = 0; c < ND * DP; c++) begin
      goto_c(c);
      if (dig != 4'hF) cnt++;
    end
    check("bright0_count", cnt, 0);

    // Snapshot: change mid digit-2 slot, visible only from the next frame.
    start(16'h1234, 4'h0, 1'b0, 4'hF);
    goto_c(130);
    disp_num = 16'h5678;
    goto_c(150); check("snap_d2_old", {dig, seg}, {4'hD, 8'hB0});
    goto_c(200); check("snap_d3_old", {dig, seg}, {4'hE, 8'h99});
    goto_c(266); check("snap_d0_new", {dig, seg}, {4'h7, 8'h92});
    goto_c(330); check("snap_d1_new", {dig, seg}, {4'hB, 8'h82});
    goto_c(394); check("snap_d2_new", {dig, seg}, {4'hD, 8'hF8});
    goto_c(458); check("snap_d3_new", {dig, seg}, {4'hE, 8'h80});

    // Enable drop mid digit 1, then re-enable.
    start(16'h1A3F, 4'h0, 1'b0, 4'hF);
    goto_c(70);
    check("drop_before", {dig, seg}, {4'hB, 8'h88});
    enable = 1'b0;
    nstep(1);
    check("drop_next_edge", {frame_done, dig, seg}, {1'b0, 4'hF, 8'hFF});
    for (int k = 0; k < 300; k++) begin
      nstep(1);
      check("drop_idle", {frame_done, dig, seg}, {1'b0, 4'hF, 8'hFF});
    end
    enable = 1'b1;
    cyc = 0;
    goto_c(1);
    check("reenable_d0", {dig, seg}, {4'h7, 8'hF9});
    while (cyc < 300) begin
      nstep(1);
      check("reenable_fd", {31'd0, frame_done}, {31'd0, (cyc == 257)});
    end

    // Asynchronous reset mid-scan forces outputs inactive before any clock edge.
    start(16'h1A3F, 4'h0, 1'b0, 4'hF);
    goto_c(70);
    check("arst_before", {dig, seg}, {4'hB, 8'h88});
    #2 rst_n = 1'b0;
    #1 check("arst_immediate", {frame_done, dig, seg}, {1'b0, 4'hF, 8'hFF});
    nstep(1);
    rst_n = 1'b1;
    nstep(1);
    check("arst_release", {frame_done, dig, seg}, {1'b0, 4'hF, 8'hFF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
